risc16_main_control: RTL
========================

Name: risc16_main_control

Overview:
- Multicycle main control FSM for the 16-bit RISC core.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives datapath strobes, and drives the 2-bit ALUOp consumed by ALU_control, which combines it with the opcode to form ALUcnt.
- Owns the memory request/ready handshake, memory timeout detection and illegal-opcode trapping.

Parameters:
- TIMEOUT_CYCLES, 15: maximum consecutive cycles a memory state may wait with mem_ready low before trapping. 0 disables the timeout.
- CNT_W, 4: width of the wait counter. Must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  4  IR[15:12]; valid from DECODE onward
- zero  in  1  ALU zero flag; sampled in BRANCH
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  1 = write, 0 = read; meaningful only with mem_req
- ir_we  out  1  load instruction register
- pc_we  out  1  load PC
- pc_src  out  2  00 = PC+2, 01 = branch target, 10 = jump target
- alu_src  out  1  0 = register B, 1 = sign-extended immediate
- alu_op  out  2  ALUOp: 00 = add (address), 01 = subtract (compare), 10 = function from opcode
- reg_we  out  1  register file write
- reg_dst  out  1  1 = rd field, 0 = rt field
- mem_to_reg  out  1  writeback source: 1 = memory data, 0 = ALU result
- retire  out  1  one-cycle pulse in the final cycle of every completed instruction
- error  out  1  sticky trap flag

Behaviour:
- Opcode map:
  - 0000 LD, 0001 ST
  - 0010..1001 R-type
  - 1011 BEQ, 1100 BNE, 1101 JMP
  - 1010, 1110, 1111 illegal
- State register and wait counter are reset asynchronously to state RST with counter 0.
- In RST every output is 0. RST always moves to FETCH on the next clock.
- Outputs are decoded from state. pc_we/ir_we in FETCH and pc_we in BRANCH additionally depend on inputs, as listed below.
- Any output not listed for a state is 0.
- States, outputs and transitions:
  - FETCH: mem_req=1, mem_we=0, alu_op=00, pc_src=00; ir_we=pc_we=mem_ready. Goes to DECODE on mem_ready.
  - DECODE: 1 cycle.
    - LD/ST -> MEM_ADDR
    - R-type -> EXEC_R
    - BEQ/BNE -> BRANCH
    - JMP -> JUMP
    - illegal -> ERROR
  - MEM_ADDR: alu_src=1, alu_op=00. LD -> MEM_RD, ST -> MEM_WR.
  - MEM_RD: mem_req=1, alu_src=1, alu_op=00. Goes to WB_MEM on mem_ready.
  - MEM_WR: mem_req=1, mem_we=1, alu_src=1, alu_op=00. On mem_ready: retire=1, then FETCH.
  - WB_MEM: reg_we=1, mem_to_reg=1, reg_dst=0, retire=1 -> FETCH.
  - EXEC_R: alu_op=10, alu_src=0 -> WB_ALU.
  - WB_ALU: alu_op=10, reg_we=1, reg_dst=1, mem_to_reg=0, retire=1 -> FETCH.
  - BRANCH: alu_op=01, pc_src=01, pc_we=(BEQ&zero)|(BNE&~zero), retire=1 -> FETCH.
  - JUMP: pc_we=1, pc_src=10, retire=1 -> FETCH.
  - ERROR: error=1, all strobes 0. Held until rst_n is asserted.
- Latency with zero-wait memory:
  - LD 5 cycles, ST 4, R-type 4, branch 3, JMP 3.
  - Each mem_ready-low cycle in FETCH, MEM_RD or MEM_WR adds 1 cycle.
- Wait counter:
  - Increments each cycle in FETCH, MEM_RD or MEM_WR while mem_ready=0.
  - Clears on any state change and on mem_ready=1.
  - If TIMEOUT_CYCLES≠0 and the counter equals TIMEOUT_CYCLES while mem_ready=0, next state is ERROR. mem_req drops on entry to ERROR.
  - mem_ready=1 in the same cycle the counter reaches its limit completes normally; ready wins.
- mem_ready outside FETCH, MEM_RD and MEM_WR is ignored.
- The counter saturates; it never wraps.
- Reset asserted mid-instruction aborts it immediately: outputs go to 0 asynchronously and there is no retire.
- error never deasserts without reset.

Decomposition:
- Package risc16_ctrl_pkg holds:
  - opcode constants
  - ALUOp encodings 00/01/10, shared with ALU_control
  - pc_src encodings
  - state enumeration as 4-bit localparams
- Optional sub-module risc16_mem_wait_timer holds the wait counter and timeout compare, with inputs clk, rst_n, waiting, clear and output expired.
- The FSM stays in one module.

Test Plan:
- Reset release with mem_ready=1 and opcode=0010 (ADD):
  - RST, FETCH, DECODE, EXEC_R, WB_ALU.
  - alu_op=10 and reg_we=reg_dst=1 in WB_ALU.
  - retire pulses in cycle 5; the next FETCH follows.
- LD with mem_ready low 3 cycles in MEM_RD:
  - mem_req held 4 cycles, alu_op=00, alu_src=1.
  - WB_MEM has mem_to_reg=1, reg_we=1; total 8 cycles from FETCH.
- BEQ with zero=1 -> pc_we=1, pc_src=01 in BRANCH. BNE with zero=1 -> pc_we=0. Both retire with alu_op=01.
- TIMEOUT_CYCLES=15 and mem_ready held low in FETCH:
  - ERROR entered after 16 wait cycles; error=1 and mem_req=0 thereafter.
  - A repeat with mem_ready=1 on the 16th cycle instead completes the fetch.
- Opcode 1110 -> DECODE then ERROR; no retire, reg_we, mem_req or pc_we. Subsequent mem_ready pulses are ignored.
- rst_n pulsed low during MEM_WR with mem_req=1:
  - mem_req and mem_we fall asynchronously, with no retire.
  - After release: RST then FETCH, and error is cleared.

Source files
------------

// File: rtl/risc16_ctrl_pkg.sv
// Shared encodings for the RISC16 main control FSM and ALU_control:
// opcodes, ALUOp, pc_src and the control state enumeration.
package risc16_ctrl_pkg;

  localparam logic [3:0] OP_LD       = 4'h0;
  localparam logic [3:0] OP_ST       = 4'h1;
  localparam logic [3:0] OP_RTYPE_LO = 4'h2;
  localparam logic [3:0] OP_RTYPE_HI = 4'h9;
  localparam logic [3:0] OP_BEQ      = 4'hB;
  localparam logic [3:0] OP_BNE      = 4'hC;
  localparam logic [3:0] OP_JMP      = 4'hD;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] PCSRC_INC = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  typedef enum logic [3:0] {
    ST_RST      = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEM_ADDR = 4'd3,
    ST_MEM_RD   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_WB_MEM   = 4'd6,
    ST_EXEC_R   = 4'd7,
    ST_WB_ALU   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JUMP     = 4'd10,
    ST_ERROR    = 4'd11
  } state_t;

  function automatic logic is_rtype(input logic [3:0] op);
    return (op >= OP_RTYPE_LO) && (op <= OP_RTYPE_HI);
  endfunction

  // Unused opcodes (1010, 1110, 1111) fall through to the trap state.
  function automatic state_t decode_next(input logic [3:0] op);
    state_t s;
    case (op)
      OP_LD, OP_ST:   s = ST_MEM_ADDR;
      OP_BEQ, OP_BNE: s = ST_BRANCH;
      OP_JMP:         s = ST_JUMP;
      default:        s = is_rtype(op) ? ST_EXEC_R : ST_ERROR;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/risc16_mem_wait_timer.sv
// Saturating count of consecutive memory-wait cycles; flags when the
// configured timeout limit has been reached.
module risc16_mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  input  logic clear,
  output logic expired
);

  localparam logic [CNT_W-1:0] W_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] W_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] W_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] W_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt;

  // Wait counter: clear wins, otherwise count up while waiting, never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= W_ZERO;
    end else if (clear) begin
      r_cnt <= W_ZERO;
    end else if (waiting && (r_cnt != W_MAX)) begin
      r_cnt <= r_cnt + W_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && (r_cnt == W_LIMIT);

endmodule

// File: rtl/risc16_main_control.sv
// Multicycle main control FSM for the RISC16 core: sequences fetch, decode,
// execute, memory and writeback, and traps on illegal opcodes or memory timeout.
module risc16_main_control
  import risc16_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       retire,
  output logic       error
);

  state_t r_state;
  state_t w_next;
  logic   w_waiting;
  logic   w_clear;
  logic   w_expired;
  logic   w_taken;

  // State register; reset forces RST so every strobe drops immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RST;
    end else begin
      r_state <= w_next;
    end
  end

  assign w_waiting = ((r_state == ST_FETCH) || (r_state == ST_MEM_RD) ||
                      (r_state == ST_MEM_WR)) && !mem_ready;
  assign w_clear   = mem_ready || (w_next != r_state);
  assign w_taken   = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);

  risc16_mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .waiting(w_waiting),
    .clear  (w_clear),
    .expired(w_expired)
  );

  // Next-state and state-decoded strobes; mem_ready is checked before the timeout.
  always_comb begin
    w_next     = r_state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PCSRC_INC;
    alu_src    = 1'b0;
    alu_op     = ALUOP_ADD;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    retire     = 1'b0;
    error      = 1'b0;
    case (r_state)
      ST_RST: begin
        w_next = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
        pc_we   = mem_ready;
        if (mem_ready) begin
          w_next = ST_DECODE;
        end else if (w_expired) begin
          w_next = ST_ERROR;
        end else begin
          w_next = ST_FETCH;
        end
      end
      ST_DECODE: begin
        w_next = decode_next(opcode);
      end
      ST_MEM_ADDR: begin
        alu_src = 1'b1;
        if (opcode == OP_ST) begin
          w_next = ST_MEM_WR;
        end else begin
          w_next = ST_MEM_RD;
        end
      end
      ST_MEM_RD: begin
        mem_req = 1'b1;
        alu_src = 1'b1;
        if (mem_ready) begin
          w_next = ST_WB_MEM;
        end else if (w_expired) begin
          w_next = ST_ERROR;
        end else begin
          w_next = ST_MEM_RD;
        end
      end
      ST_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        alu_src = 1'b1;
        if (mem_ready) begin
          retire = 1'b1;
          w_next = ST_FETCH;
        end else if (w_expired) begin
          w_next = ST_ERROR;
        end else begin
          w_next = ST_MEM_WR;
        end
      end
      ST_WB_MEM: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        w_next     = ST_FETCH;
      end
      ST_EXEC_R: begin
        alu_op = ALUOP_FUNC;
        w_next = ST_WB_ALU;
      end
      ST_WB_ALU: begin
        alu_op  = ALUOP_FUNC;
        reg_we  = 1'b1;
        reg_dst = 1'b1;
        retire  = 1'b1;
        w_next  = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_op = ALUOP_SUB;
        pc_src = PCSRC_BR;
        pc_we  = w_taken;
        retire = 1'b1;
        w_next = ST_FETCH;
      end
      ST_JUMP: begin
        pc_we  = 1'b1;
        pc_src = PCSRC_JMP;
        retire = 1'b1;
        w_next = ST_FETCH;
      end
      ST_ERROR: begin
        error  = 1'b1;
        w_next = ST_ERROR;
      end
      default: begin
        w_next = ST_ERROR;
      end
    endcase
  end

endmodule
